// File: rtl/i2c_pkg.sv
// i2c_pkg: bus constants and one-hot FSM encoding shared by the I2C initiator and target
package i2c_pkg;
    typedef enum logic [7:0] {
        IDLE     = 8'h01,
        ADDR     = 8'h02,
        ADDR_ACK = 8'h04,
        WR_BYTE  = 8'h08,
        WR_ACK   = 8'h10,
        RD_BYTE  = 8'h20,
        RD_ACK   = 8'h40,
        IGNORE   = 8'h80
    } i2c_state_e;
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: SCL/SDA synchronizers with SCL edge, START and STOP detection
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic RESET,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic scl_d, sda_d;
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end
    assign scl_s     = scl_q[SYNC_STAGES-1];
    assign sda_s     = sda_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SCL must be high on both samples so a data change racing an SCL edge is not taken as a condition
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit address I2C target exchanging a fixed 16-bit word (MSB byte first)
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        SCL,
    input  logic        SDA_IN,
    output logic        SDA_OUT,
    output logic        SDA_OE,
    input  logic [15:0] TX_DATA,
    output logic [15:0] RX_DATA,
    output logic        RX_VALID,
    output logic        BUSY
);
    i2c_state_e state, state_n;
    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] bit_cnt;
    logic [1:0] byte_cnt, byte_inc;
    logic [7:0] shreg, rx_hi;
    logic [15:0] tx_sh;
    logic rw, m_ack, got_rise;
    logic in_ack, shifting, byte_end, ack_end, addr_hit;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .RESET(RESET),
        .scl(SCL),
        .sda(SDA_IN),
        .scl_s(scl_s),
        .sda_s(sda_s),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start_det(start_det),
        .stop_det(stop_det)
    );

    assign in_ack   = state inside {ADDR_ACK, WR_ACK, RD_ACK};
    assign shifting = state inside {ADDR, WR_BYTE, RD_BYTE};
    assign byte_end = scl_rise && bit_cnt == 3'd7;
    // ack phases span two falls: the first drives the ACK slot, the one after the 9th rise leaves it
    assign ack_end  = scl_fall && got_rise;
    assign addr_hit = shreg[6:0] == TARGET_ADDR;
    assign byte_inc = byte_cnt + {1'b0, byte_cnt != 2'd2};

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (stop_det) state_n = IDLE;
        else if (start_det) state_n = ADDR;
        else case (state)
            ADDR:     if (byte_end) state_n = addr_hit ? ADDR_ACK : IGNORE;
            ADDR_ACK: if (ack_end) state_n = rw == RW_READ ? RD_BYTE : WR_BYTE;
            WR_BYTE:  if (byte_end) state_n = WR_ACK;
            WR_ACK:   if (ack_end) state_n = WR_BYTE;
            RD_BYTE:  if (scl_fall && bit_cnt == 3'd0) state_n = RD_ACK;
            RD_ACK:   if (ack_end) state_n = m_ack == I2C_ACK ? RD_BYTE : IGNORE;
            default:  state_n = state;
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            SDA_OUT  <= 1'b1;
            SDA_OE   <= 1'b0;
            RX_DATA  <= 16'h0000;
            RX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            shreg    <= 8'h00;
            rx_hi    <= 8'h00;
            tx_sh    <= 16'hFFFF;
            rw       <= RW_WRITE;
            m_ack    <= I2C_NACK;
            got_rise <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            if (stop_det || start_det) begin
                SDA_OUT  <= 1'b1;
                SDA_OE   <= 1'b0;
                BUSY     <= 1'b0;
                bit_cnt  <= 3'd0;
                byte_cnt <= 2'd0;
                got_rise <= 1'b0;
            end else begin
                got_rise <= scl_fall ? 1'b0 : (scl_rise && in_ack) ? 1'b1 : got_rise;
                if (scl_rise && shifting) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shreg   <= {shreg[6:0], sda_s};
                end
                if (byte_end && state == ADDR) begin
                    rw   <= sda_s;
                    BUSY <= addr_hit;
                end
                if (state == RD_ACK && scl_s) m_ack <= sda_s;
                if (scl_fall) case (state)
                    ADDR_ACK: begin
                        SDA_OE  <= !got_rise || rw == RW_READ;
                        SDA_OUT <= !got_rise ? I2C_ACK : rw == RW_READ ? TX_DATA[15] : 1'b1;
                        if (got_rise) tx_sh <= {TX_DATA[14:0], 1'b1};
                    end
                    WR_ACK: begin
                        SDA_OE  <= !got_rise && byte_cnt != 2'd2;
                        SDA_OUT <= got_rise || byte_cnt == 2'd2;
                        if (got_rise) begin
                            byte_cnt <= byte_inc;
                            if (byte_cnt == 2'd0) rx_hi <= shreg;
                            if (byte_cnt == 2'd1) begin
                                RX_DATA  <= {rx_hi, shreg};
                                RX_VALID <= 1'b1;
                            end
                        end
                    end
                    RD_BYTE: begin
                        SDA_OUT <= bit_cnt == 3'd0 ? 1'b1 : tx_sh[15];
                        if (bit_cnt == 3'd0) begin
                            SDA_OE   <= 1'b0;
                            byte_cnt <= byte_inc;
                        end else tx_sh <= {tx_sh[14:0], 1'b1};
                    end
                    RD_ACK: if (got_rise && m_ack == I2C_ACK) begin
                        // past the second byte the word is exhausted: keep SDA released (reads as 8'hFF)
                        SDA_OE  <= byte_cnt != 2'd2;
                        SDA_OUT <= tx_sh[15];
                        tx_sh   <= {tx_sh[14:0], 1'b1};
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
